// File: rtl/bit_serializer.sv
// bit_serializer: parallel-in / serial-out stage feeding the det_1011 detector's `in` port.
// Latency: a word accepted on edge k drives its first bit after edge k+1 and its last bit after edge k+WIDTH.
// Backpressure: single holding register; registered din_ready is low while it is full, so back-to-back words run bubble-free.
// Ports: clk, rstn (async, active-low) | din/din_valid/din_ready word handshake |
//        ser_out/out_valid/sof/eow framed serial stream | busy = shifting, gapping or holding a word.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   LSB_FIRST = 1'b0,
    parameter int   GAP       = 0,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             out_valid,
    output logic             sof,
    output logic             eow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);
    localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    logic [1:0]       state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic [3:0]       gapcnt;

    logic             take;
    logic             drain;
    logic             hold_full_nxt;
    logic [WIDTH-1:0] sr_shift;
    logic             first_bit;
    logic             next_bit;

    always_comb begin
        take  = din_valid & din_ready;
        // The held word moves into the shifter whenever the serial side is free:
        // from IDLE, at the end of a word when there is no gap, or at the end of the gap.
        drain = hold_full & ((state == S_IDLE) |
                             ((state == S_SHIFT) & (cnt == CNT_LAST) & (GAP == 0)) |
                             ((state == S_GAP) & (gapcnt == 4'd0)));
        hold_full_nxt = hold_full;
        if (take) begin
            hold_full_nxt = 1'b1;
        end else if (drain) begin
            hold_full_nxt = 1'b0;
        end
        // The output end of sr is bit WIDTH-1 for MSB-first and bit 0 for LSB-first.
        sr_shift  = LSB_FIRST ? {1'b0, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], 1'b0};
        first_bit = LSB_FIRST ? hold[0] : hold[WIDTH-1];
        next_bit  = LSB_FIRST ? sr_shift[0] : sr_shift[WIDTH-1];
    end

    assign busy = (state != S_IDLE) | hold_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            sr        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            gapcnt    <= 4'd0;
            din_ready <= 1'b0;
            ser_out   <= IDLE_BIT;
            out_valid <= 1'b0;
            sof       <= 1'b0;
            eow       <= 1'b0;
        end else begin
            if (take) begin
                hold <= din;
            end
            hold_full <= hold_full_nxt;
            // Tracks the next value of hold_full, so ready is never high while the register is full.
            din_ready <= ~hold_full_nxt;

            case (state)
                S_IDLE: begin
                    ser_out   <= IDLE_BIT;
                    out_valid <= 1'b0;
                    sof       <= 1'b0;
                    eow       <= 1'b0;
                end
                S_SHIFT: begin
                    if (cnt != CNT_LAST) begin
                        sr      <= sr_shift;
                        cnt     <= cnt + 1'b1;
                        ser_out <= next_bit;
                        sof     <= 1'b0;
                        eow     <= (cnt == CNT_PEN);
                    end else begin
                        ser_out   <= IDLE_BIT;
                        out_valid <= 1'b0;
                        sof       <= 1'b0;
                        eow       <= 1'b0;
                        if (GAP > 0) begin
                            state  <= S_GAP;
                            gapcnt <= GAP_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    ser_out   <= IDLE_BIT;
                    out_valid <= 1'b0;
                    if (gapcnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        gapcnt <= gapcnt - 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    ser_out   <= IDLE_BIT;
                    out_valid <= 1'b0;
                    sof       <= 1'b0;
                    eow       <= 1'b0;
                end
            endcase

            // A load overrides whatever the state branch chose above.
            if (drain) begin
                state     <= S_SHIFT;
                sr        <= hold;
                cnt       <= '0;
                ser_out   <= first_bit;
                out_valid <= 1'b1;
                sof       <= 1'b1;
                eow       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: drives three serializer variants (MSB-first, GAP=2/IDLE_BIT=1, LSB-first)
// Expected outputs come from a per-word timing model: each accepted word owns a start cycle,
// its bits occupy start..start+7, and a later word starts no earlier than prev_end+GAP+1.
module tb_bit_serializer;

    localparam int NI   = 3;
    localparam int MAXW = 256;
    localparam int MAXQ = 128;

    localparam int P_LSB  [NI] = '{0, 0, 1};
    localparam int P_GAP  [NI] = '{0, 2, 0};
    localparam bit P_IDLE [NI] = '{1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] din       [NI];
    logic       din_valid [NI];
    logic       din_ready [NI];
    logic       ser_out   [NI];
    logic       out_valid [NI];
    logic       sof       [NI];
    logic       eow       [NI];
    logic       busy      [NI];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP(0), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rstn(rstn), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
        .ser_out(ser_out[0]), .out_valid(out_valid[0]), .sof(sof[0]), .eow(eow[0]), .busy(busy[0]));

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP(2), .IDLE_BIT(1'b1)) u_gap (
        .clk(clk), .rstn(rstn), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
        .ser_out(ser_out[1]), .out_valid(out_valid[1]), .sof(sof[1]), .eow(eow[1]), .busy(busy[1]));

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP(0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rstn(rstn), .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
        .ser_out(ser_out[2]), .out_valid(out_valid[2]), .sof(sof[2]), .eow(eow[2]), .busy(busy[2]));

    int         checks;
    int         failures;
    int         x;                 // rising edges since the last reset release
    int         w_acc   [NI][MAXW];
    int         w_start [NI][MAXW];
    logic [7:0] w_dat   [NI][MAXW];
    int         w_cnt   [NI];
    logic [7:0] sq      [NI][MAXQ];
    int         sq_n    [NI];
    int         sq_h    [NI];
    int         vp      [NI];
    logic [3:0] hist;
    int         det_cnt;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic word_bit(input int i, input logic [7:0] d, input int pos);
        return (P_LSB[i] != 0) ? d[pos] : d[7 - pos];
    endfunction

    function automatic logic hold_at(input int i);
        logic h = 1'b0;
        for (int n = 0; n < w_cnt[i]; n++) begin
            if (x >= w_acc[i][n] && x < w_start[i][n]) h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic model_rdy(input int i);
        return (x >= 1) && !hold_at(i);
    endfunction

    function automatic logic quiet(input int i);
        if (sq_h[i] < sq_n[i]) return 1'b0;
        if (w_cnt[i] == 0) return 1'b1;
        return x > w_start[i][w_cnt[i]-1] + 7 + P_GAP[i] + 1;
    endfunction

    task automatic add_word(input int i, input int k, input logic [7:0] d);
        int s;
        int pe;
        s = k + 1;
        if (w_cnt[i] > 0) begin
            pe = w_start[i][w_cnt[i]-1] + 7;
            if (pe + P_GAP[i] + 1 > s) s = pe + P_GAP[i] + 1;
        end
        if (w_cnt[i] < MAXW) begin
            w_acc[i][w_cnt[i]]   = k;
            w_start[i][w_cnt[i]] = s;
            w_dat[i][w_cnt[i]]   = d;
            w_cnt[i]++;
        end
    endtask

    task automatic check_inst(input int i);
        logic ev, es, esof, eeow, ehold, egap;
        ev = 1'b0; es = P_IDLE[i]; esof = 1'b0; eeow = 1'b0; egap = 1'b0;
        ehold = hold_at(i);
        for (int n = 0; n < w_cnt[i]; n++) begin
            int s;
            int e;
            s = w_start[i][n];
            e = s + 7;
            if (x >= s && x <= e) begin
                ev   = 1'b1;
                es   = word_bit(i, w_dat[i][n], x - s);
                esof = (x == s);
                eeow = (x == e);
            end
            if (x > e && x <= e + P_GAP[i]) egap = 1'b1;
        end
        chk($sformatf("din_ready[%0d] x=%0d", i, x), din_ready[i], model_rdy(i));
        chk($sformatf("out_valid[%0d] x=%0d", i, x), out_valid[i], ev);
        chk($sformatf("ser_out[%0d] x=%0d", i, x), ser_out[i], es);
        chk($sformatf("sof[%0d] x=%0d", i, x), sof[i], esof);
        chk($sformatf("eow[%0d] x=%0d", i, x), eow[i], eeow);
        chk($sformatf("busy[%0d] x=%0d", i, x), busy[i], ev | ehold | egap);
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) check_inst(i);
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s din_ready[%0d]", tag, i), din_ready[i], 1'b0);
            chk($sformatf("%s ser_out[%0d]", tag, i), ser_out[i], P_IDLE[i]);
            chk($sformatf("%s out_valid[%0d]", tag, i), out_valid[i], 1'b0);
            chk($sformatf("%s sof[%0d]", tag, i), sof[i], 1'b0);
            chk($sformatf("%s eow[%0d]", tag, i), eow[i], 1'b0);
            chk($sformatf("%s busy[%0d]", tag, i), busy[i], 1'b0);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d);
        if (sq_n[i] < MAXQ) begin
            sq[i][sq_n[i]] = d;
            sq_n[i]++;
        end
    endtask

    // One cycle: compare at the falling edge, drive inputs, advance the model on the rising edge.
    task automatic step();
        logic xfer [NI];
        check_all();
        if (out_valid[0] === 1'b1) begin
            hist = {hist[2:0], ser_out[0]};
            if (hist == 4'b1011) det_cnt++;
        end
        for (int i = 0; i < NI; i++) begin
            if (sq_h[i] < sq_n[i] && int'($urandom_range(0, 99)) < vp[i]) begin
                din_valid[i] = 1'b1;
                din[i]       = sq[i][sq_h[i]];
            end else begin
                din_valid[i] = 1'b0;
                din[i]       = 8'($urandom);
            end
            xfer[i] = din_valid[i] && model_rdy(i);
        end
        @(posedge clk);
        x++;
        for (int i = 0; i < NI; i++) begin
            if (xfer[i]) begin
                add_word(i, x, sq[i][sq_h[i]]);
                sq_h[i]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_drain(input string tag, input int budget);
        int c = 0;
        while (!(quiet(0) && quiet(1) && quiet(2)) && c < budget) begin
            step();
            c++;
        end
        chk({tag, " drained_in_budget"}, quiet(0) && quiet(1) && quiet(2), 1'b1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NI; i++) begin
            w_cnt[i] = 0; sq_n[i] = 0; sq_h[i] = 0; vp[i] = 100;
            din_valid[i] = 1'b0; din[i] = 8'h00;
        end
        x = 0; hist = 4'h0; det_cnt = 0;
    endtask

    initial begin
        int base;
        int c;
        checks = 0; failures = 0;
        rstn = 1'b0;
        clear_model();

        // Reset values, held across a few edges.
        repeat (3) @(negedge clk);
        check_reset("reset");
        rstn = 1'b1;
        x = 0;

        // Single words: B0 MSB-first, FF/00 through the gap variant, 0D LSB-first.
        push(0, 8'hB0);
        push(1, 8'hFF); push(1, 8'h00);
        push(2, 8'h0D);
        run_drain("single", 200);
        chk_int("det_1011_hits_B0", det_cnt, 1);

        // Back-to-back pair with valid held high.
        push(0, 8'hA5); push(0, 8'h3C);
        run_drain("pair", 200);

        // Three queued words under backpressure.
        for (int n = 0; n < 3; n++) push(0, 8'($urandom));
        run_drain("three", 200);

        // Random words with random valid duty on all variants.
        for (int i = 0; i < NI; i++) begin
            vp[i] = int'($urandom_range(30, 100));
            for (int n = 0; n < 30; n++) push(i, 8'($urandom));
        end
        run_drain("random", 3000);

        // Reset asserted on the 4th bit of a word while a second word is held.
        vp[0] = 100;
        base = w_cnt[0];
        push(0, 8'($urandom)); push(0, 8'($urandom));
        c = 0;
        while (!(w_cnt[0] > base && x == w_start[0][base] + 3) && c < 100) begin
            step();
            c++;
        end
        chk("reached_4th_bit", w_cnt[0] > base && x == w_start[0][base] + 3, 1'b1);
        check_all();
        rstn = 1'b0;
        #1;
        check_reset("mid_reset");
        clear_model();
        repeat (2) @(negedge clk);
        check_reset("mid_reset_held");
        rstn = 1'b1;
        x = 0;
        for (int n = 0; n < 20; n++) step();

        // Function resumes after the mid-word reset.
        for (int i = 0; i < NI; i++) begin
            push(i, 8'($urandom)); push(i, 8'($urandom));
        end
        run_drain("post_reset", 200);
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
